// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: picks the next fetch PC from
// exception, exception-return, branch, deferred-branch and sequential sources.
module pc_gen #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = 32'hBFC00000,
  parameter logic [ADDR_W-1:0]  EXC_VEC   = 32'hBFC00380,
  parameter int                 N_STALL   = 4,
  parameter int                 CNT_W     = 8,
  parameter int                 INC       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_STALL-1:0]  stall,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [ADDR_W-1:0]   epc,
  input  logic                br_valid,
  input  logic [ADDR_W-1:0]   br_target,
  output logic [ADDR_W-1:0]   pc,
  output logic                pc_valid,
  output logic                pend_valid,
  output logic                pc_misaligned,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                stall_timeout
);

  // Which source feeds the PC register this cycle; BR_DEFER and HOLD keep pc.
  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_ERET,
    SRC_BR,
    SRC_BR_DEFER,
    SRC_HOLD,
    SRC_PEND,
    SRC_SEQ
  } src_e;

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              misaligned_q, misaligned_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              stall_any;
  src_e              src;

  assign stall_any = |stall;

  always_comb begin
    src = SRC_SEQ;
    if (exc_req)           src = SRC_EXC;
    else if (eret_req)     src = SRC_ERET;
    else if (br_valid)     src = stall_any ? SRC_BR_DEFER : SRC_BR;
    else if (stall_any)    src = SRC_HOLD;
    else if (pend_valid_q) src = SRC_PEND;
  end

  always_comb begin
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    case (src)
      SRC_EXC: begin
        pc_d         = EXC_VEC;
        pend_valid_d = 1'b0;
      end
      SRC_ERET: begin
        pc_d         = epc;
        pend_valid_d = 1'b0;
      end
      SRC_BR: begin
        pc_d         = br_target;
        pend_valid_d = 1'b0;
      end
      SRC_BR_DEFER: begin
        // Newest branch wins; an older deferred target is simply overwritten.
        pend_addr_d  = br_target;
        pend_valid_d = 1'b1;
      end
      SRC_PEND: begin
        pc_d         = pend_addr_q;
        pend_valid_d = 1'b0;
      end
      SRC_SEQ:  pc_d = pc_q + INC_V;
      default:  pc_d = pc_q;
    endcase
    misaligned_d = (pc_d[1:0] != 2'b00);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!stall_any || exc_req || eret_req) stall_cnt_d = '0;
    else if (stall_cnt_q != CNT_MAX)       stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_VEC;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      misaligned_q <= (RESET_VEC[1:0] != 2'b00);
      stall_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      misaligned_q <= misaligned_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // pc_valid: the fetch at pc is issued in this cycle when high; no ready side.
  assign pc_valid      = rst_n & ~stall_any;
  assign pc            = pc_q;
  assign pend_valid    = pend_valid_q;
  assign pc_misaligned = misaligned_q;
  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = (stall_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, a long-stall saturation sequence
// and randomized traffic compared against a behavioural model.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic [3:0]  stall;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pend_valid;
  logic        pc_misaligned;
  logic [7:0]  stall_cnt;
  logic        stall_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pa;
  int          m_cnt;

  typedef struct {
    logic        rst_n;
    logic [3:0]  stall;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        brv;
    logic [31:0] brt;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic [7:0]  exp_cnt;
    logic        exp_mis;
  } vec_t;

  pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pend_valid   (pend_valid),
    .pc_misaligned(pc_misaligned),
    .stall_cnt    (stall_cnt),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Next-state rules of the PC generator, written from the request priorities.
  task automatic model_step(input logic r, input logic [3:0] s, input logic e,
                            input logic er, input logic [31:0] ep,
                            input logic bv, input logic [31:0] bt);
    logic sa;
    sa = (s != 4'b0);
    if (!r) begin
      m_pc = 32'hBFC00000; m_pv = 1'b0; m_pa = 32'h0; m_cnt = 0;
    end else begin
      if (e)             begin m_pc = 32'hBFC00380; m_pv = 1'b0; end
      else if (er)       begin m_pc = ep; m_pv = 1'b0; end
      else if (sa)       begin if (bv) begin m_pa = bt; m_pv = 1'b1; end end
      else if (bv)       begin m_pc = bt; m_pv = 1'b0; end
      else if (m_pv)     begin m_pc = m_pa; m_pv = 1'b0; end
      else               m_pc = m_pc + 32'd4;
      if (!sa || e || er) m_cnt = 0;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  // Drive one cycle of inputs, check pc_valid before the edge and all
  // registered outputs against the model after it.
  task automatic cycle(input logic r, input logic [3:0] s, input logic e,
                       input logic er, input logic [31:0] ep,
                       input logic bv, input logic [31:0] bt);
    rst_n = r; stall = s; exc_req = e; eret_req = er; epc = ep;
    br_valid = bv; br_target = bt;
    #1;
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, r & (s == 4'b0)});
    model_step(r, s, e, er, ep, bv, bt);
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("pend_valid", {31'b0, pend_valid}, {31'b0, m_pv});
    chk("stall_cnt", {24'b0, stall_cnt}, 32'(m_cnt));
    chk("stall_timeout", {31'b0, stall_timeout}, {31'b0, m_cnt == 255});
    chk("pc_misaligned", {31'b0, pc_misaligned}, {31'b0, m_pc[1:0] != 2'b00});
  endtask

  initial begin
    vec_t vt[$];
    rst_n = 1'b0; stall = '0; exc_req = 0; eret_req = 0; epc = '0;
    br_valid = 0; br_target = '0;
    m_pc = '0; m_pv = 0; m_pa = '0; m_cnt = 0;
    @(posedge clk); #1;

    //        rst  stall   exc eret epc           brv brt           exp_pc        pend cnt mis
    vt.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00000, 0, 0, 0});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00004, 0, 0, 0});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00008, 0, 0, 0});
    vt.push_back('{1, 4'b0100, 0, 0, 32'h0,        1, 32'h80001000, 32'hBFC00008, 1, 1, 0});
    vt.push_back('{1, 4'b0100, 0, 0, 32'h0,        0, 32'h0,        32'hBFC00008, 1, 2, 0});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'h80001000, 0, 0, 0});
    vt.push_back('{1, 4'b0001, 0, 0, 32'h0,        1, 32'h12345678, 32'h80001000, 1, 1, 0});
    vt.push_back('{1, 4'b0001, 1, 0, 32'h0,        1, 32'h55555554, 32'hBFC00380, 0, 0, 0});
    vt.push_back('{1, 4'b0001, 0, 0, 32'h0,        1, 32'h00002000, 32'hBFC00380, 1, 1, 0});
    vt.push_back('{1, 4'b1000, 0, 0, 32'h0,        1, 32'h00003000, 32'hBFC00380, 1, 2, 0});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'h00003000, 0, 0, 0});
    vt.push_back('{1, 4'b0010, 0, 0, 32'h0,        1, 32'h44440000, 32'h00003000, 1, 1, 0});
    vt.push_back('{0, 4'b0010, 1, 0, 32'h0,        1, 32'h0,        32'hBFC00000, 0, 0, 0});
    vt.push_back('{1, 4'b0000, 0, 1, 32'h80000002, 0, 32'h0,        32'h80000002, 0, 0, 1});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'h80000006, 0, 0, 1});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0});
    vt.push_back('{1, 4'b0000, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 0, 0, 0});
    vt.push_back('{1, 4'b0001, 0, 1, 32'h00000100, 1, 32'h9000,     32'h00000100, 0, 0, 0});

    foreach (vt[i]) begin
      rst_n = vt[i].rst_n; stall = vt[i].stall; exc_req = vt[i].exc;
      eret_req = vt[i].eret; epc = vt[i].epc; br_valid = vt[i].brv;
      br_target = vt[i].brt;
      #1;
      chk($sformatf("vec%0d pc_valid", i), {31'b0, pc_valid},
          {31'b0, vt[i].rst_n & (vt[i].stall == 4'b0)});
      @(posedge clk); #1;
      chk($sformatf("vec%0d pc", i), pc, vt[i].exp_pc);
      chk($sformatf("vec%0d pend_valid", i), {31'b0, pend_valid}, {31'b0, vt[i].exp_pend});
      chk($sformatf("vec%0d stall_cnt", i), {24'b0, stall_cnt}, {24'b0, vt[i].exp_cnt});
      chk($sformatf("vec%0d pc_misaligned", i), {31'b0, pc_misaligned}, {31'b0, vt[i].exp_mis});
    end

    // Long stall: counter saturates at 255 and timeout asserts exactly there.
    rst_n = 1; exc_req = 0; eret_req = 0; br_valid = 0; stall = 4'b0100;
    for (int c = 1; c <= 260; c++) begin
      @(posedge clk); #1;
      if (c == 254) begin
        chk("sat cnt254", {24'b0, stall_cnt}, 32'd254);
        chk("sat timeout254", {31'b0, stall_timeout}, 32'd0);
      end
      if (c == 255) begin
        chk("sat cnt255", {24'b0, stall_cnt}, 32'd255);
        chk("sat timeout255", {31'b0, stall_timeout}, 32'd1);
      end
    end
    chk("sat hold cnt", {24'b0, stall_cnt}, 32'd255);
    chk("sat hold timeout", {31'b0, stall_timeout}, 32'd1);
    chk("sat hold pc", pc, 32'h00000100);
    stall = 4'b0000;
    @(posedge clk); #1;
    chk("sat release cnt", {24'b0, stall_cnt}, 32'd0);
    chk("sat release pc", pc, 32'h00000104);

    // Randomized traffic against the model, starting from a fresh reset.
    cycle(1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, e, er, bv;
      logic [3:0]  s;
      logic [31:0] ep, bt;
      r  = ($urandom_range(0, 60) != 0);
      s  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      if (n >= 1000 && n < 1400) s = 4'b0010;
      e  = ($urandom_range(0, 30) == 0);
      er = ($urandom_range(0, 25) == 0);
      bv = ($urandom_range(0, 5) == 0);
      ep = $urandom;
      bt = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      cycle(r, s, e, er, ep, bv, bt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
